// File: rtl/dtc_vote_window_if.sv
// Sample/result handshake bundle for the dtc majority-vote window stage.
// master = sample producer and result consumer; slave = the voting block.
interface dtc_vote_window_if #(
    parameter int unsigned OUT_W = 7,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] inp;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] outp;
    logic [CNT_W-1:0] out_n;

    modport master (
        output in_valid, inp, flush, out_ready,
        input  in_ready, out_valid, outp, out_n
    );

    modport slave (
        input  in_valid, inp, flush, out_ready,
        output in_ready, out_valid, outp, out_n
    );
endinterface

// File: rtl/dtc_vote_window.sv
// Bitwise strict-majority vote over a window of classifier codes.
// A window closes at WIN samples or on flush; the result is held until the consumer takes it.
module dtc_vote_window #(
    parameter int unsigned OUT_W = 7,
    parameter int unsigned WIN   = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    dtc_vote_window_if.slave  bus
);
    localparam logic [CNT_W-1:0] WIN_N = CNT_W'(WIN);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] w_n_nxt;
    logic [CNT_W-1:0] w_n_inc;
    logic [OUT_W-1:0] r_outp;
    logic [OUT_W-1:0] w_outp_nxt;
    logic [CNT_W-1:0] r_out_n;
    logic [CNT_W-1:0] w_out_n_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [OUT_W-1:0] w_vote;
    logic             w_accept;
    logic             w_close;
    logic             w_clear;

    // in_ready looks only at state and reset, never at in_valid
    assign bus.in_ready  = (r_state == ACCUM) && !rst;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_n_inc       = r_n + CNT_W'(w_accept);

    // Flush only closes a window that holds at least one sample, counting this cycle's
    assign w_close = (r_state == ACCUM) &&
                     ((w_accept && (w_n_inc == WIN_N)) ||
                      (bus.flush && (w_n_inc != '0)));

    assign bus.out_valid = r_out_valid;
    assign bus.outp      = r_outp;
    assign bus.out_n     = r_out_n;

    // Per-bit ones counter and vote; compare 2*cnt > n one bit wider so it cannot overflow
    for (genvar g = 0; g < OUT_W; g++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_inc;

        assign w_cnt_inc = r_cnt + CNT_W'(w_accept && bus.inp[g]);
        assign w_vote[g] = {w_cnt_inc, 1'b0} > {1'b0, w_n_inc};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_clear) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_n         <= '0;
            r_outp      <= '0;
            r_out_n     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_n         <= w_n_nxt;
            r_outp      <= w_outp_nxt;
            r_out_n     <= w_out_n_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state: accumulate until close, then hold the vote until it is taken
    always_comb begin
        w_state_nxt     = r_state;
        w_n_nxt         = r_n;
        w_outp_nxt      = r_outp;
        w_out_n_nxt     = r_out_n;
        w_out_valid_nxt = r_out_valid;
        w_clear         = 1'b0;
        case (r_state)
            ACCUM: begin
                w_n_nxt = w_n_inc;
                if (w_close) begin
                    w_state_nxt     = HOLD;
                    w_outp_nxt      = w_vote;
                    w_out_n_nxt     = w_n_inc;
                    w_out_valid_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt     = ACCUM;
                    w_n_nxt         = '0;
                    w_out_valid_nxt = 1'b0;
                    w_clear         = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end
endmodule

// File: tb/tb_dtc_vote_window.sv
// Self-checking bench for dtc_vote_window: vector table plus scoreboard of voted results.
module tb_dtc_vote_window;
    localparam int unsigned OUT_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN   = 8;

    typedef struct {
        logic [7:0][6:0] codes;
        int              n;
        logic            fl;
        logic [6:0]      eoutp;
        logic [7:0]      en;
    } vec_t;

    typedef struct {
        logic [6:0] outp;
        logic [7:0] n;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];
    vec_t tbl[8];
    logic mon_prev = 1'b0;

    always #5 clk = ~clk;

    dtc_vote_window_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();
    dtc_vote_window_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus1 ();

    dtc_vote_window #(.OUT_W(OUT_W), .WIN(WIN), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dtc_vote_window #(.OUT_W(OUT_W), .WIN(1), .CNT_W(CNT_W)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference vote: bit set only when ones strictly outnumber zeros
    function automatic logic [6:0] vote(input logic [7:0][6:0] codes, input int n);
        logic [6:0] res;
        for (int b = 0; b < 7; b++) begin
            int ones = 0;
            for (int k = 0; k < n; k++) ones += int'(codes[k][b]);
            res[b] = (2 * ones > n);
        end
        return res;
    endfunction

    // Scoreboard: each new assertion of out_valid must match the oldest pending result
    always @(negedge clk) begin
        if (rst) begin
            mon_prev = 1'b0;
        end else begin
            if (bus.out_valid && !mon_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got outp=%b out_n=%0d with nothing expected", bus.outp, bus.out_n);
                end else begin
                    res_t r;
                    r = sb.pop_front();
                    check("sb_outp", 32'(bus.outp), 32'(r.outp));
                    check("sb_out_n", 32'(bus.out_n), 32'(r.n));
                end
            end
            mon_prev = bus.out_valid;
        end
    end

    task automatic send(input logic [6:0] c, input logic f);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.inp      = c;
        bus.flush    = f;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", t);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit gaps);
        sb.push_back('{v.eoutp, v.en});
        for (int k = 0; k < v.n; k++) begin
            send(v.codes[k], v.fl && (k == v.n - 1));
            if (gaps && k < v.n - 1) repeat ($urandom_range(0, 3)) tick();
        end
        check("close_out_valid", 32'(bus.out_valid), 32'd1);
        check("close_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("ack_out_valid", 32'(bus.out_valid), 32'd0);
        check("ack_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bus.in_valid  = 1'b0;
        bus.inp       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.inp       = '0;
        bus1.flush     = 1'b0;
        bus1.out_ready = 1'b1;
        rst = 1'b1;

        for (int k = 0; k < 8; k++) tbl[0].codes[k] = (k < 5) ? 7'b0110111 : 7'b1011011;
        tbl[0].n = 8; tbl[0].fl = 1'b0; tbl[0].eoutp = 7'b0110111; tbl[0].en = 8'd8;
        for (int k = 0; k < 8; k++) tbl[1].codes[k] = (k < 4) ? 7'b0000111 : 7'b0100001;
        tbl[1].n = 8; tbl[1].fl = 1'b0; tbl[1].eoutp = 7'b0000001; tbl[1].en = 8'd8;
        tbl[2].codes = '0;
        tbl[2].codes[0] = 7'b0011111; tbl[2].codes[1] = 7'b0011111; tbl[2].codes[2] = 7'b0000000;
        tbl[2].n = 3; tbl[2].fl = 1'b1; tbl[2].eoutp = 7'b0011111; tbl[2].en = 8'd3;
        tbl[3].codes = '0;
        tbl[3].codes[0] = 7'b1010101;
        tbl[3].n = 1; tbl[3].fl = 1'b1; tbl[3].eoutp = 7'b1010101; tbl[3].en = 8'd1;
        for (int k = 0; k < 8; k++) tbl[4].codes[k] = (k < 4) ? 7'b1111111 : 7'b0000000;
        tbl[4].n = 7; tbl[4].fl = 1'b1; tbl[4].eoutp = 7'b1111111; tbl[4].en = 8'd7;
        tbl[5].codes = '0;
        tbl[5].codes[0] = 7'b1100000; tbl[5].codes[1] = 7'b0000011;
        tbl[5].n = 2; tbl[5].fl = 1'b1; tbl[5].eoutp = 7'b0000000; tbl[5].en = 8'd2;
        for (int e = 6; e < 8; e++) begin
            for (int k = 0; k < 8; k++) tbl[e].codes[k] = 7'($urandom);
            tbl[e].n  = (e == 6) ? 8 : int'($urandom_range(1, 7));
            tbl[e].fl = (e == 7);
            tbl[e].eoutp = vote(tbl[e].codes, tbl[e].n);
            tbl[e].en = 8'(tbl[e].n);
        end

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outp", 32'(bus.outp), 32'd0);
        check("rst_out_n", 32'(bus.out_n), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int e = 0; e < 8; e++) run_vec(tbl[e], 1'b0);

        // Same majority window with idle gaps
        run_vec(tbl[0], 1'b1);

        // Backpressure: result held, nothing counted while in_valid stays high
        sb.push_back('{7'b0110111, 8'd8});
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(tbl[0].codes[k], 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.inp = 7'($urandom);
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_outp", 32'(bus.outp), 32'(7'b0110111));
            check("bp_out_n", 32'(bus.out_n), 32'd8);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_keep_outp", 32'(bus.outp), 32'(7'b0110111));
        run_vec(tbl[1], 1'b0);

        // Flush on an empty window does nothing
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (3) tick();
        check("flush_idle_valid", 32'(bus.out_valid), 32'd0);
        check("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset mid-window discards partial counts
        for (int k = 0; k < 5; k++) send(7'b0011111, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_outp", 32'(bus.outp), 32'd0);
        check("midrst_out_n", 32'(bus.out_n), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) v.codes[k] = 7'b0011111;
        v.n = 8; v.fl = 1'b0; v.eoutp = 7'b0011111; v.en = 8'd8;
        run_vec(v, 1'b0);

        // WIN=1: every sample is its own window
        for (int c = 0; c < 4; c++) begin
            logic [6:0] code;
            int t;
            code = (c == 0) ? 7'b1010101 : 7'($urandom);
            t = 0;
            bus1.inp      = code;
            bus1.in_valid = 1'b1;
            while (!bus1.in_ready && t < 50) begin
                tick();
                t++;
            end
            tick();
            bus1.in_valid = 1'b0;
            check("win1_out_valid", 32'(bus1.out_valid), 32'd1);
            check("win1_outp", 32'(bus1.outp), 32'(code));
            check("win1_out_n", 32'(bus1.out_n), 32'd1);
            tick();
            check("win1_ack_valid", 32'(bus1.out_valid), 32'd0);
        end

        repeat (2) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
